// File: rtl/zip_memchk_if.sv
// CPU-to-memory-unit observation bundle: the monitored signals plus the checker's status outputs.
// The checker only reads the monitored side, so it never backpressures anything.
interface zip_memchk_if #(
  parameter int LGDEPTH = 2,
  parameter int LGCOUNT = 16
);
  logic               i_cpu_reset;
  logic               i_stb;
  logic               i_pipe_stalled;
  logic [2:0]         i_op;
  logic [4:0]         i_oreg;
  logic               i_lock;
  logic               i_busy;
  logic               i_rdbusy;
  logic               i_valid;
  logic               i_done;
  logic               i_err;
  logic [4:0]         i_wreg;
  logic [LGDEPTH:0]   o_outstanding;
  logic               o_read_cycle;
  logic [4:0]         o_expected_reg;
  logic               o_fault;
  logic [3:0]         o_fault_code;
  logic [LGCOUNT-1:0] o_returns;
  logic [LGCOUNT-1:0] o_errors;

  modport master (
    output i_cpu_reset, i_stb, i_pipe_stalled, i_op, i_oreg, i_lock,
           i_busy, i_rdbusy, i_valid, i_done, i_err, i_wreg,
    input  o_outstanding, o_read_cycle, o_expected_reg, o_fault, o_fault_code,
           o_returns, o_errors
  );

  modport slave (
    input  i_cpu_reset, i_stb, i_pipe_stalled, i_op, i_oreg, i_lock,
           i_busy, i_rdbusy, i_valid, i_done, i_err, i_wreg,
    output o_outstanding, o_read_cycle, o_expected_reg, o_fault, o_fault_code,
           o_returns, o_errors
  );
endinterface

// File: rtl/zip_memchk.sv
// Passive CPU/memory-unit protocol checker: tracks outstanding requests, latches the first fault.
// All status is registered (one-cycle latency); it observes only and never stalls the bus.
module zip_memchk #(
  parameter int LGDEPTH  = 2,
  parameter bit OPT_LOCK = 1'b0,
  parameter int LGCOUNT  = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  zip_memchk_if.slave   bus
);
  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] FULL_CNT = (LGDEPTH+1)'(DEPTH);

  typedef struct packed {
    logic       is_read;
    logic [4:0] oreg;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [LGDEPTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGDEPTH:0]     cnt_q, cnt_d;
  logic                 read_cycle_q, read_cycle_d;
  logic                 fault_q, fault_d;
  logic [3:0]           code_q, code_d;
  logic [LGCOUNT-1:0]   returns_q, returns_d, errors_q, errors_d;
  logic                 err_prev_q, err_prev_d, crst_prev_q, crst_prev_d;
  logic                 stall_q, stall_d, stall_lock_q, stall_lock_d;
  logic [4:0]           stall_oreg_q, stall_oreg_d;
  logic [2:0]           stall_op_q, stall_op_d;

  logic                 empty, full, accept, flush, pop, push;
  entry_t               head;
  logic [11:1]          hit;
  logic [3:0]           first_code;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign accept = bus.i_stb && !bus.i_pipe_stalled && !bus.i_cpu_reset;
  assign flush  = bus.i_err || bus.i_cpu_reset;
  assign pop    = bus.i_done && !empty && !flush;
  // A full FIFO only takes a new entry when the head leaves in the same cycle.
  assign push   = accept && !flush && (!full || pop);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{is_read: !bus.i_op[0], oreg: bus.i_oreg};
      wr_ptr_d        = wr_ptr_q + LGDEPTH'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (LGDEPTH+1)'(1);
      2'b01:   cnt_d = cnt_q - (LGDEPTH+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    read_cycle_d = read_cycle_q;
    if (accept && !flush)
      read_cycle_d = !bus.i_op[0];
    if (cnt_d == '0)
      read_cycle_d = 1'b0;
  end

  always_comb begin
    hit     = '0;
    hit[1]  = (bus.i_done && empty) || (bus.i_err && empty && !accept);
    hit[2]  = accept && full && !pop;
    hit[3]  = bus.i_valid && !empty && !head.is_read;
    hit[4]  = bus.i_valid && !empty && (bus.i_wreg != head.oreg);
    hit[5]  = bus.i_stb && (bus.i_err || err_prev_q || crst_prev_q);
    hit[6]  = accept && !empty && (!bus.i_op[0] != read_cycle_q);
    hit[7]  = bus.i_stb && bus.i_lock && !OPT_LOCK;
    hit[8]  = bus.i_rdbusy && !bus.i_busy;
    hit[9]  = bus.i_valid && !bus.i_done;
    hit[10] = bus.i_stb && (bus.i_op[2:1] == 2'b00);
    hit[11] = stall_q && !bus.i_cpu_reset &&
              (!bus.i_stb || (bus.i_oreg != stall_oreg_q) ||
               (bus.i_op != stall_op_q) || (bus.i_lock != stall_lock_q));

    // Scan downward so the lowest-numbered active code is the one kept.
    first_code = 4'd0;
    for (int k = 11; k >= 1; k--)
      if (hit[k])
        first_code = 4'(k);

    fault_d = fault_q;
    code_d  = code_q;
    if (!fault_q && (hit != '0)) begin
      fault_d = 1'b1;
      code_d  = first_code;
    end

    returns_d = returns_q;
    if (bus.i_valid && !(&returns_q))
      returns_d = returns_q + LGCOUNT'(1);
    errors_d = errors_q;
    if (bus.i_err && !(&errors_q))
      errors_d = errors_q + LGCOUNT'(1);

    err_prev_d   = bus.i_err;
    crst_prev_d  = bus.i_cpu_reset;
    stall_d      = bus.i_stb && bus.i_pipe_stalled && !bus.i_cpu_reset;
    stall_oreg_d = bus.i_oreg;
    stall_op_d   = bus.i_op;
    stall_lock_d = bus.i_lock;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      read_cycle_q <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= '0;
      returns_q    <= '0;
      errors_q     <= '0;
      err_prev_q   <= 1'b0;
      crst_prev_q  <= 1'b0;
      stall_q      <= 1'b0;
      stall_oreg_q <= '0;
      stall_op_q   <= '0;
      stall_lock_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      read_cycle_q <= read_cycle_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      returns_q    <= returns_d;
      errors_q     <= errors_d;
      err_prev_q   <= err_prev_d;
      crst_prev_q  <= crst_prev_d;
      stall_q      <= stall_d;
      stall_oreg_q <= stall_oreg_d;
      stall_op_q   <= stall_op_d;
      stall_lock_q <= stall_lock_d;
    end
  end

  assign bus.o_outstanding  = cnt_q;
  assign bus.o_read_cycle   = read_cycle_q;
  assign bus.o_expected_reg = empty ? 5'd0 : head.oreg;
  assign bus.o_fault        = fault_q;
  assign bus.o_fault_code   = code_q;
  assign bus.o_returns      = returns_q;
  assign bus.o_errors       = errors_q;
endmodule

// File: tb/tb_zip_memchk.sv
// Directed bench for zip_memchk: ordering, overflow, error flush, stall rules, fault priority, async reset.
module tb_zip_memchk;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  zip_memchk_if #(.LGDEPTH(2), .LGCOUNT(16)) bus ();

  zip_memchk #(.LGDEPTH(2), .OPT_LOCK(1'b0), .LGCOUNT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.i_cpu_reset    = 1'b0;
    bus.i_stb          = 1'b0;
    bus.i_pipe_stalled = 1'b0;
    bus.i_op           = 3'b100;
    bus.i_oreg         = 5'd0;
    bus.i_lock         = 1'b0;
    bus.i_busy         = 1'b0;
    bus.i_rdbusy       = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_done         = 1'b0;
    bus.i_err          = 1'b0;
    bus.i_wreg         = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic accept_rd(input logic [4:0] r);
    bus.i_stb  = 1'b1;
    bus.i_op   = 3'b100;
    bus.i_oreg = r;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    vectors++;
    if ({bus.o_outstanding, bus.o_read_cycle, bus.o_expected_reg, bus.o_fault,
         bus.o_fault_code, bus.o_returns, bus.o_errors} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got cnt=%0d rc=%0d exp=%0d f=%0d code=%0d ret=%0d err=%0d want all 0",
               bus.o_outstanding, bus.o_read_cycle, bus.o_expected_reg, bus.o_fault,
               bus.o_fault_code, bus.o_returns, bus.o_errors);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.i_stb = 1'b1; bus.i_op = 3'b100; bus.i_oreg = 5'(i);
      step();
      vectors++;
      if (bus.o_outstanding !== 3'(i)) begin
        miscompares++;
        $display("FAIL in_order_push%0d outstanding got %0d want %0d", i, bus.o_outstanding, i);
      end
    end
    idle();
    vectors++;
    if (bus.o_expected_reg !== 5'd1 || bus.o_read_cycle !== 1'b1) begin
      miscompares++;
      $display("FAIL in_order_head got reg=%0d rc=%0d want reg=1 rc=1", bus.o_expected_reg, bus.o_read_cycle);
    end
    for (int i = 1; i <= 3; i++) begin
      bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'(i);
      step();
      vectors++;
      if (bus.o_outstanding !== 3'(3 - i)) begin
        miscompares++;
        $display("FAIL in_order_pop%0d outstanding got %0d want %0d", i, bus.o_outstanding, 3 - i);
      end
    end
    idle();
    step();
    vectors++;
    if (bus.o_returns !== 16'd3 || bus.o_fault !== 1'b0 || bus.o_read_cycle !== 1'b0 ||
        bus.o_expected_reg !== 5'd0) begin
      miscompares++;
      $display("FAIL in_order_end got ret=%0d f=%0d rc=%0d reg=%0d want ret=3 f=0 rc=0 reg=0",
               bus.o_returns, bus.o_fault, bus.o_read_cycle, bus.o_expected_reg);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    accept_rd(5'd4);
    accept_rd(5'd5);
    bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'd5;
    step();
    idle();
    vectors++;
    if (bus.o_fault !== 1'b1 || bus.o_fault_code !== 4'd4) begin
      miscompares++;
      $display("FAIL ooo_fault got f=%0d code=%0d want f=1 code=4", bus.o_fault, bus.o_fault_code);
    end
    bus.i_cpu_reset = 1'b1;
    step();
    idle();
    step();
    vectors++;
    if (bus.o_outstanding !== 3'd0 || bus.o_fault !== 1'b1 || bus.o_fault_code !== 4'd4 ||
        bus.o_returns !== 16'd1) begin
      miscompares++;
      $display("FAIL ooo_cpu_reset got cnt=%0d f=%0d code=%0d ret=%0d want cnt=0 f=1 code=4 ret=1",
               bus.o_outstanding, bus.o_fault, bus.o_fault_code, bus.o_returns);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) accept_rd(5'(i));
    vectors++;
    if (bus.o_outstanding !== 3'd4 || bus.o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL full_fill got cnt=%0d f=%0d want cnt=4 f=0", bus.o_outstanding, bus.o_fault);
    end
    accept_rd(5'd5);
    vectors++;
    if (bus.o_fault_code !== 4'd2 || bus.o_outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow got code=%0d cnt=%0d want code=2 cnt=4", bus.o_fault_code, bus.o_outstanding);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) accept_rd(5'(i));
    bus.i_stb = 1'b1; bus.i_op = 3'b100; bus.i_oreg = 5'd5;
    bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'd1;
    step();
    idle();
    vectors++;
    if (bus.o_fault !== 1'b0 || bus.o_outstanding !== 3'd4 || bus.o_expected_reg !== 5'd2) begin
      miscompares++;
      $display("FAIL full_pushpop got f=%0d cnt=%0d reg=%0d want f=0 cnt=4 reg=2",
               bus.o_fault, bus.o_outstanding, bus.o_expected_reg);
    end
    // Drain across the pointer wrap; the fifth entry sits in the reused slot 0.
    for (int i = 2; i <= 5; i++) begin
      bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'(i);
      step();
    end
    idle();
    vectors++;
    if (bus.o_fault !== 1'b0 || bus.o_outstanding !== 3'd0 || bus.o_returns !== 16'd5) begin
      miscompares++;
      $display("FAIL wrap_drain got f=%0d code=%0d cnt=%0d ret=%0d want f=0 cnt=0 ret=5",
               bus.o_fault, bus.o_fault_code, bus.o_outstanding, bus.o_returns);
    end
  endtask

  task automatic test_bus_error();
    do_reset();
    accept_rd(5'd1);
    accept_rd(5'd2);
    bus.i_err = 1'b1;
    step();
    idle();
    vectors++;
    if (bus.o_outstanding !== 3'd0 || bus.o_errors !== 16'd1 || bus.o_read_cycle !== 1'b0 ||
        bus.o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL err_flush got cnt=%0d err=%0d rc=%0d f=%0d want cnt=0 err=1 rc=0 f=0",
               bus.o_outstanding, bus.o_errors, bus.o_read_cycle, bus.o_fault);
    end
    accept_rd(5'd3);
    vectors++;
    if (bus.o_fault_code !== 4'd5) begin
      miscompares++;
      $display("FAIL stb_after_err got code=%0d want 5", bus.o_fault_code);
    end
  endtask

  task automatic test_stall(input logic with_lock, input logic [3:0] want);
    do_reset();
    bus.i_stb = 1'b1; bus.i_pipe_stalled = 1'b1; bus.i_op = 3'b100; bus.i_oreg = 5'd1;
    step();
    vectors++;
    if (bus.o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold got f=%0d want 0", bus.o_fault);
    end
    bus.i_pipe_stalled = 1'b0; bus.i_oreg = 5'd2; bus.i_lock = with_lock;
    step();
    idle();
    vectors++;
    if (bus.o_fault !== 1'b1 || bus.o_fault_code !== want) begin
      miscompares++;
      $display("FAIL stall_change lock=%0d got f=%0d code=%0d want f=1 code=%0d",
               with_lock, bus.o_fault, bus.o_fault_code, want);
    end
  endtask

  task automatic test_misc_codes();
    do_reset();
    bus.i_done = 1'b1;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd1) begin
      miscompares++; $display("FAIL done_empty got code=%0d want 1", bus.o_fault_code);
    end
    do_reset();
    bus.i_stb = 1'b1; bus.i_op = 3'b101; bus.i_oreg = 5'd7;
    step(); idle();
    bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'd7;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd3) begin
      miscompares++; $display("FAIL valid_on_write got code=%0d want 3", bus.o_fault_code);
    end
    do_reset();
    accept_rd(5'd1);
    bus.i_stb = 1'b1; bus.i_op = 3'b101; bus.i_oreg = 5'd2;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd6) begin
      miscompares++; $display("FAIL dir_change got code=%0d want 6", bus.o_fault_code);
    end
    do_reset();
    bus.i_rdbusy = 1'b1;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd8) begin
      miscompares++; $display("FAIL rdbusy_idle got code=%0d want 8", bus.o_fault_code);
    end
    do_reset();
    accept_rd(5'd1);
    bus.i_valid = 1'b1; bus.i_wreg = 5'd1;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd9) begin
      miscompares++; $display("FAIL valid_no_done got code=%0d want 9", bus.o_fault_code);
    end
    do_reset();
    bus.i_stb = 1'b1; bus.i_op = 3'b000; bus.i_oreg = 5'd1;
    step(); idle();
    vectors++;
    if (bus.o_fault_code !== 4'd10) begin
      miscompares++; $display("FAIL size_zero got code=%0d want 10", bus.o_fault_code);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    accept_rd(5'd1);
    bus.i_valid = 1'b1; bus.i_done = 1'b1; bus.i_wreg = 5'd2;
    step(); idle();
    bus.i_err = 1'b1;
    step(); idle();
    accept_rd(5'd3);
    vectors++;
    if (bus.o_fault_code !== 4'd4 || bus.o_returns !== 16'd1 || bus.o_errors !== 16'd1 ||
        bus.o_outstanding !== 3'd1 || bus.o_expected_reg !== 5'd3) begin
      miscompares++;
      $display("FAIL pre_reset got code=%0d ret=%0d err=%0d cnt=%0d reg=%0d want 4 1 1 1 3",
               bus.o_fault_code, bus.o_returns, bus.o_errors, bus.o_outstanding, bus.o_expected_reg);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.o_outstanding, bus.o_read_cycle, bus.o_expected_reg, bus.o_fault,
         bus.o_fault_code, bus.o_returns, bus.o_errors} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got cnt=%0d rc=%0d reg=%0d f=%0d code=%0d ret=%0d err=%0d want all 0",
               bus.o_outstanding, bus.o_read_cycle, bus.o_expected_reg, bus.o_fault,
               bus.o_fault_code, bus.o_returns, bus.o_errors);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_overflow();
    test_full_push_pop();
    test_bus_error();
    test_stall(1'b0, 4'd11);
    test_stall(1'b1, 4'd7);
    test_misc_codes();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
